fw_array_feeder: RTL and testbench

Issuer that drives instruction and data words into PE 0 of the FW linear processing array, producing the transmit side of the `instr`/data stream that each PE decodes. On a `start` pulse it runs one tile: it streams the ls0 load, then the ls1 load, then the compute sweep from a source stream, and finally drains the array pipeline. It sits between the tile buffer (valid/ready source) and the head of the PE chain.

---
 rtl/fw_array_feeder.sv | 194 +++++++++++++++++++
 tb/tb_fw_array_feeder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fw_array_feeder.sv
// rtl/fw_array_feeder.sv - tile issuer driving READ0/READ1/COMPUTE words into PE 0 of the FW array
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef B
`define B 8
`endif
`ifndef L
`define L 4
`endif
`ifndef logB
`define logB 3
`endif
`ifndef logL
`define logL 2
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 2
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 8
`endif
`ifndef IDLE
`define IDLE 2'd0
`endif
`ifndef READ0
`define READ0 2'd1
`endif
`ifndef READ1
`define READ1 2'd2
`endif
`ifndef COMPUTE
`define COMPUTE 2'd3
`endif

module fw_array_feeder #(
   parameter int NPE   = `B,
   parameter int WORDS = `B / `L,
   parameter int DRAIN = 3 * NPE
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [`L*`WIDTH-1:0]     src_data,
   input  logic                     src_valid,
   output logic                     src_ready,
   output logic [`L*`WIDTH-1:0]     out,
   output logic [`INSTR_WIDTH-1:0]  instr_out,
   output logic                     busy,
   output logic                     done
);

   localparam int DW  = `L * `WIDTH;
   localparam int IW  = `INSTR_WIDTH;
   localparam int AW  = IW - 1 - `OP_WIDTH - `logL;
   localparam int PW  = (NPE > 1) ? $clog2(NPE) : 1;
   localparam int WW  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD0,
      ST_LOAD1,
      ST_COMPUTE,
      ST_DRAIN
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   pe_cnt, pe_cnt_nxt;
   logic [PW-1:0]   piv_cnt, piv_cnt_nxt;
   logic [WW-1:0]   word_cnt, word_cnt_nxt;
   logic [DCW-1:0]  drain_cnt, drain_cnt_nxt;
   logic [DW-1:0]   out_nxt;
   logic [IW-1:0]   instr_nxt;
   logic            busy_nxt, done_nxt;
   logic            last_word;

   // Top bit stays 0; fields from low to high: opcode, part select, address.
   function automatic logic [IW-1:0] make_instr(input logic [`OP_WIDTH-1:0] op,
                                                 input logic [`logL-1:0]     part,
                                                 input logic [AW-1:0]        addr);
      return {1'b0, addr, part, op};
   endfunction

   localparam logic [IW-1:0] BUBBLE = {1'b0, {AW{1'b0}}, {`logL{1'b0}}, `IDLE};

   assign last_word = (word_cnt == WW'(WORDS - 1));

   // Source is only accepted while one of the streaming phases is active.
   always_comb begin
      src_ready = (state == ST_LOAD0) || (state == ST_LOAD1) || (state == ST_COMPUTE);
   end

   // Next-state, counter and output-word selection; a stall emits a bubble and holds everything.
   always_comb begin
      state_nxt     = state;
      pe_cnt_nxt    = pe_cnt;
      piv_cnt_nxt   = piv_cnt;
      word_cnt_nxt  = word_cnt;
      drain_cnt_nxt = drain_cnt;
      out_nxt       = '0;
      instr_nxt     = BUBBLE;
      busy_nxt      = 1'b1;
      done_nxt      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy_nxt = 1'b0;
            if (start) begin
               state_nxt     = ST_LOAD0;
               pe_cnt_nxt    = '0;
               piv_cnt_nxt   = '0;
               word_cnt_nxt  = '0;
               drain_cnt_nxt = '0;
               busy_nxt      = 1'b1;
            end
         end
         ST_LOAD0, ST_LOAD1: begin
            if (src_valid) begin
               instr_nxt = make_instr((state == ST_LOAD0) ? `READ0 : `READ1, '0, AW'(pe_cnt));
               out_nxt   = src_data;
               if (last_word) begin
                  word_cnt_nxt = '0;
                  if (pe_cnt == PW'(NPE - 1)) begin
                     pe_cnt_nxt = '0;
                     state_nxt  = (state == ST_LOAD0) ? ST_LOAD1 : ST_COMPUTE;
                  end else begin
                     pe_cnt_nxt = pe_cnt + 1'b1;
                  end
               end else begin
                  word_cnt_nxt = word_cnt + 1'b1;
               end
            end
         end
         ST_COMPUTE: begin
            if (src_valid) begin
               instr_nxt = make_instr(`COMPUTE, `logL'(piv_cnt % `L), AW'(piv_cnt / `L));
               out_nxt   = src_data;
               if (last_word) begin
                  word_cnt_nxt = '0;
                  if (piv_cnt == PW'(NPE - 1)) begin
                     piv_cnt_nxt   = '0;
                     drain_cnt_nxt = '0;
                     state_nxt     = ST_DRAIN;
                  end else begin
                     piv_cnt_nxt = piv_cnt + 1'b1;
                  end
               end else begin
                  word_cnt_nxt = word_cnt + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == DCW'(DRAIN - 1)) begin
               drain_cnt_nxt = '0;
               state_nxt     = ST_IDLE;
               busy_nxt      = 1'b0;
               done_nxt      = 1'b1;
            end else begin
               drain_cnt_nxt = drain_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs; reset abandons any tile in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         pe_cnt    <= '0;
         piv_cnt   <= '0;
         word_cnt  <= '0;
         drain_cnt <= '0;
         out       <= '0;
         instr_out <= BUBBLE;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         pe_cnt    <= pe_cnt_nxt;
         piv_cnt   <= piv_cnt_nxt;
         word_cnt  <= word_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
         out       <= out_nxt;
         instr_out <= instr_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_fw_array_feeder.sv
// tb/tb_fw_array_feeder.sv - directed self-checking bench for fw_array_feeder
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef L
`define L 4
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 8
`endif

module tb_fw_array_feeder;

   localparam int NWORDS  = 48;
   localparam int DRAIN_C = 24;

   logic                    clk;
   logic                    reset;
   logic                    start;
   logic [`L*`WIDTH-1:0]    src_data;
   logic                    src_valid;
   logic                    src_ready;
   logic [`L*`WIDTH-1:0]    out;
   logic [`INSTR_WIDTH-1:0] instr_out;
   logic                    busy;
   logic                    done;

   int checks   = 0;
   int failures = 0;

   fw_array_feeder dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .src_data  (src_data),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .out       (out),
      .instr_out (instr_out),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Word w of a tile: 0..15 READ0, 16..31 READ1, 32..47 COMPUTE; two words per PE/pivot.
   function automatic logic [7:0] exp_instr(input int w);
      int seg;
      int piv;
      seg = w / 16;
      piv = (w % 16) / 2;
      if (seg == 0)      return 8'((piv << 4) | 1);
      else if (seg == 1) return 8'((piv << 4) | 2);
      else               return 8'(((piv / 4) << 4) | ((piv % 4) << 2) | 3);
   endfunction

   // start_mode: 0 single pulse, 1 extra pulses in COMPUTE and DRAIN, 2 start held high.
   task automatic run_tile(input int stall_every, input int start_mode);
      int w;
      int cyc;
      int stalls;
      int last;
      bit sv;
      bit ed;
      bit fin;
      logic [7:0]  ei;
      logic [31:0] eo;
      w = 0; cyc = 0; stalls = 0; last = -1; fin = 0;
      start = 1'b1; src_valid = 1'b0; src_data = '0;
      @(posedge clk); #1;
      if (start_mode != 2) start = 1'b0;
      check("go_busy", busy, 1);
      check("go_ready", src_ready, 1);
      while (!fin && cyc < 400) begin
         sv = !(stall_every != 0 && (cyc % stall_every) == stall_every - 1);
         if (w < NWORDS && !sv) stalls++;
         src_valid = sv;
         src_data  = 32'(w);
         if (start_mode == 1) start = (cyc == 40 || cyc == 60);
         #1;
         check("ready", src_ready, w < NWORDS);
         @(posedge clk); #1;
         cyc++;
         ei = 8'h00; eo = 32'h0;
         if (sv && w < NWORDS) begin
            ei = exp_instr(w);
            eo = 32'(w);
            w++;
            if (w == NWORDS) last = cyc;
         end
         ed = (last >= 0) && (cyc == last + DRAIN_C);
         check("instr", instr_out, ei);
         check("out", out, eo);
         check("done", done, ed);
         check("busy", busy, !ed);
         if (ed) fin = 1;
      end
      check("tile_finish", fin, 1);
      check("done_cycle", cyc, 72 + stalls);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_instr", instr_out, 0);
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", src_ready, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset mid-LOAD1 with source still valid.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         src_valid = 1'b1; src_data = 32'(i);
         @(posedge clk); #1;
      end
      check("mid_instr_read1", instr_out, exp_instr(19));
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_instr", instr_out, 0);
      check("abort_out", out, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", src_ready, 0);
      reset = 1'b0; src_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; src_valid = 1'b1; src_data = 32'hAA;
      @(posedge clk); #1;
      check("restart_instr", instr_out, 8'h01);
      check("restart_out", out, 32'hAA);
      src_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Continuous source.
      run_tile(0, 0);
      @(posedge clk); #1;
      check("post_done", done, 0);
      check("post_busy", busy, 0);

      // Gap every third cycle.
      run_tile(3, 0);
      @(posedge clk); #1;
      check("stall_post_done", done, 0);
      check("stall_post_busy", busy, 0);

      // Stray starts in COMPUTE and DRAIN.
      run_tile(0, 1);
      @(posedge clk); #1;
      check("stray_done", done, 0);
      check("stray_busy", busy, 0);
      check("stray_ready", src_ready, 0);
      check("stray_instr", instr_out, 0);

      // Start held: one IDLE cycle, then the next tile's LOAD0.
      run_tile(0, 2);
      src_valid = 1'b1; src_data = 32'h0;
      @(posedge clk); #1;
      check("b2b_busy", busy, 1);
      check("b2b_ready", src_ready, 1);
      check("b2b_done", done, 0);
      check("b2b_idle_instr", instr_out, 0);
      src_data = 32'h5;
      @(posedge clk); #1;
      check("b2b_first_instr", instr_out, 8'h01);
      check("b2b_first_out", out, 32'h5);
      start = 1'b0; src_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
